// File: rtl/fsr_fill_seq.sv
// fsr_fill_seq: fills a block of file registers via FSR/INDF over the shared bus.
// Define FSR_FILL_RESTORE_EN to save and restore the program-visible FSR around a fill.
module fsr_fill_seq #(
    parameter int ADDR_W = 5,
    parameter int LEN_W  = 6
) (
    input  logic              clock_i,
    input  logic              reset_n_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [LEN_W-1:0]  length_i,
    input  logic [7:0]        fill_value_i,
    output logic              bus_req_o,
    input  logic              bus_gnt_i,
    output logic              bus_drive_en_o,
    output logic [7:0]        bus_data_out_o,
    input  logic [7:0]        bus_data_in_i,
    output logic              fsr_write_en_o,
    output logic              fsr_out_en_o,
    input  logic [ADDR_W-1:0] fsr_in_i,
    output logic              indf_write_en_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o
);
    typedef enum logic [2:0] {
        IDLE, REQ, LOAD, WRITE, DONE
`ifdef FSR_FILL_RESTORE_EN
        , SAVE, RESTORE
`endif
    } state_t;

`ifdef FSR_FILL_RESTORE_EN
    localparam state_t GRANTED = SAVE;
    localparam state_t FINAL   = RESTORE;
`else
    localparam state_t GRANTED = LOAD;
    localparam state_t FINAL   = DONE;
`endif

    state_t            state_q;
    logic [ADDR_W-1:0] cur_addr_q;
    logic [LEN_W-1:0]  remaining_q;
    logic [7:0]        fill_q;
    logic              error_q;
    logic              match;
    logic              save_st;
    logic              restore_st;
    logic [7:0]        saved_w;

`ifdef FSR_FILL_RESTORE_EN
    logic [7:0] saved_q;
    assign save_st    = state_q == SAVE;
    assign restore_st = state_q == RESTORE;
    assign saved_w    = saved_q;
`else
    logic unused_bus_in;
    assign unused_bus_in = ^bus_data_in_i;
    assign save_st       = 1'b0;
    assign restore_st    = 1'b0;
    assign saved_w       = '0;
`endif

    assign match = fsr_in_i == cur_addr_q;

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            fill_q      <= '0;
            error_q     <= 1'b0;
`ifdef FSR_FILL_RESTORE_EN
            saved_q     <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: if (start_i) begin
                    cur_addr_q  <= base_addr_i;
                    remaining_q <= length_i;
                    fill_q      <= fill_value_i;
                    error_q     <= 1'b0;
                    state_q     <= (length_i == '0) ? DONE : REQ;
                end
                REQ: if (bus_gnt_i) state_q <= GRANTED;
`ifdef FSR_FILL_RESTORE_EN
                SAVE: if (bus_gnt_i) begin
                    saved_q <= bus_data_in_i;
                    state_q <= LOAD;
                end
                RESTORE: if (bus_gnt_i) state_q <= DONE;
`endif
                LOAD: if (bus_gnt_i) state_q <= WRITE;
                // An FSR that does not hold the address just loaded aborts the fill.
                WRITE: if (bus_gnt_i) begin
                    if (!match) begin
                        error_q <= 1'b1;
                        state_q <= FINAL;
                    end else begin
                        remaining_q <= remaining_q - LEN_W'(1);
                        cur_addr_q  <= cur_addr_q + ADDR_W'(1);
                        state_q     <= (remaining_q == LEN_W'(1)) ? FINAL : LOAD;
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Every enable is qualified by the live grant so the bus is released the cycle it is taken away.
    assign bus_req_o       = state_q != IDLE && state_q != DONE;
    assign busy_o          = bus_req_o;
    assign done_o          = state_q == DONE;
    assign error_o         = error_q;
    assign fsr_write_en_o  = bus_gnt_i && (state_q == LOAD || restore_st);
    assign indf_write_en_o = bus_gnt_i && state_q == WRITE && match;
    assign fsr_out_en_o    = bus_gnt_i && save_st;
    assign bus_drive_en_o  = fsr_write_en_o || indf_write_en_o;
    assign bus_data_out_o  = !bus_drive_en_o ? '0 :
                             state_q == WRITE ? fill_q :
                             state_q == LOAD ? {{(8-ADDR_W){1'b0}}, cur_addr_q} : saved_w;
endmodule

// File: tb/tb_fsr_fill_seq.sv
// tb_fsr_fill_seq: randomized fills checked against an abstract step-count and write-list model.
module tb_fsr_fill_seq;
    localparam int AW = 5;
    localparam int LW = 6;
`ifdef FSR_FILL_RESTORE_EN
    localparam int EXTRA = 2;
`else
    localparam int EXTRA = 0;
`endif

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          bus_gnt = 1'b1;
    logic [AW-1:0] base_addr = '0;
    logic [LW-1:0] length = '0;
    logic [7:0]    fill_value = '0;
    logic          bus_req, bus_drive_en, fsr_write_en, fsr_out_en, indf_write_en, busy, done, error;
    logic [7:0]    bus_data_out, bus_data_in;
    logic [AW-1:0] fsr_in;

    logic [AW-1:0] fsr = '0;
    int            load_n = 0, wr_n = 0, viol = 0, req_cnt = 0, done_cnt = 0;
    logic [7:0]    load_log [0:4095];
    logic [AW-1:0] wr_addr [0:4095];
    logic [7:0]    wr_data [0:4095];
    int            corrupt_k = 0, txn_load0 = 0;
    logic          gl [0:511];
    int            n_tests = 0, n_fail = 0;

    fsr_fill_seq #(.ADDR_W(AW), .LEN_W(LW)) dut (
        .clock_i(clock), .reset_n_i(reset_n), .start_i(start),
        .base_addr_i(base_addr), .length_i(length), .fill_value_i(fill_value),
        .bus_req_o(bus_req), .bus_gnt_i(bus_gnt), .bus_drive_en_o(bus_drive_en),
        .bus_data_out_o(bus_data_out), .bus_data_in_i(bus_data_in),
        .fsr_write_en_o(fsr_write_en), .fsr_out_en_o(fsr_out_en), .fsr_in_i(fsr_in),
        .indf_write_en_o(indf_write_en), .busy_o(busy), .done_o(done), .error_o(error)
    );

    always #5 clock = ~clock;

    // FSR/RAM stand-in: the FSR can be made to lie right after the k-th load of a transaction.
    assign fsr_in      = fsr ^ AW'(corrupt_k != 0 && load_n - txn_load0 == corrupt_k);
    assign bus_data_in = fsr_out_en ? 8'(fsr) : 8'hEE;

    always @(posedge clock) begin
        if (fsr_write_en) begin
            fsr              <= bus_data_out[AW-1:0];
            load_log[load_n] <= bus_data_out;
            load_n           <= load_n + 1;
        end
        if (indf_write_en) begin
            wr_addr[wr_n] <= fsr;
            wr_data[wr_n] <= bus_data_out;
            wr_n          <= wr_n + 1;
        end
    end

    always @(negedge clock) begin
        if (!bus_gnt && (bus_drive_en || fsr_write_en || fsr_out_en || indf_write_en)) viol <= viol + 1;
        if (bus_req) req_cnt <= req_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Each pass of REQ, LOAD, WRITE, SAVE or RESTORE consumes one granted edge.
    task automatic run(input int base, input int len, input int fill, input int corrupt, output int t);
        int k, need, exp_t, c, l0, w0, v0, r0, d0, j;
        logic [AW-1:0] fsr0;
        k = corrupt != 0 ? corrupt : len;
        need = len == 0 ? 0 : 1 + 2 * k + EXTRA;
        exp_t = -1;
        c = 0;
        if (need == 0) exp_t = 0;
        else for (int i = 1; i < 400; i++) if (!gl[i]) begin
            c++;
            if (c == need) begin exp_t = i; break; end
        end
        l0 = load_n; w0 = wr_n; v0 = viol; r0 = req_cnt; d0 = done_cnt; fsr0 = fsr;
        corrupt_k = corrupt;
        txn_load0 = load_n;
        base_addr = AW'(base); length = LW'(len); fill_value = 8'(fill);
        start = 1'b1;
        bus_gnt = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        base_addr = ~base_addr; length = '1; fill_value = ~fill_value;
        check("err_clr", int'(error), 0);
        if (len > 0) check("busy_start", int'(busy), 1);
        t = done ? 0 : -1;
        j = 0;
        while (t < 0 && j < 400) begin
            j++;
            bus_gnt = !gl[j];
            @(posedge clock); #1;
            if (done) t = j;
        end
        bus_gnt = 1'b1;
        check("latency", t, exp_t);
        check("busy_at_done", int'(busy), 0);
        check("req_at_done", int'(bus_req), 0);
        check("error", int'(error), int'(corrupt != 0));
        check("wr_count", wr_n - w0, corrupt != 0 ? corrupt - 1 : len);
        for (int i = 0; i < (corrupt != 0 ? corrupt - 1 : len); i++) begin
            check("wr_addr", int'(wr_addr[w0 + i]), (base + i) % 32);
            check("wr_data", int'(wr_data[w0 + i]), fill);
        end
        check("load_count", load_n - l0, len == 0 ? 0 : k + EXTRA / 2);
        for (int i = 0; i < (len == 0 ? 0 : k); i++)
            check("fsr_load", int'(load_log[l0 + i]), (base + i) % 32);
`ifdef FSR_FILL_RESTORE_EN
        check("fsr_kept", int'(fsr), int'(fsr0));
`endif
        if (len == 0) check("no_req", req_cnt - r0, 0);
        check("gnt_gate", viol - v0, 0);
        @(posedge clock); #1;
        check("done_pulse", int'(done), 0);
        check("done_count", done_cnt - d0, 1);
        corrupt_k = 0;
    endtask

    initial begin
        int t, len;
        for (int i = 0; i < 512; i++) gl[i] = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_req", int'(bus_req), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(error), 0);
        check("rst_drive", int'(bus_drive_en), 0);
        reset_n = 1'b1;
        @(posedge clock); #1;

        run(4, 3, 8'hA5, 0, t);
        check("lat_basic", t, 7 + EXTRA);
        run(31, 2, 8'h3C, 0, t);
        run(9, 0, 8'h77, 0, t);
        check("lat_zero", t, 0);
        for (int i = 1; i <= 5; i++) gl[i] = 1'b1;
        for (int i = 10; i <= 12; i++) gl[i] = 1'b1;
        run(2, 4, 8'h5E, 0, t);
        check("lat_stall", t, 17 + EXTRA);
        for (int i = 0; i < 512; i++) gl[i] = 1'b0;
        run(12, 4, 8'hC3, 2, t);
        run(20, 1, 8'h11, 0, t);
        run(30, 32, 8'h99, 0, t);

        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < 512; i++) gl[i] = $urandom_range(3) == 0;
            len = $urandom_range(32);
            run($urandom_range(31), len, $urandom_range(255),
                (len > 0 && $urandom_range(4) == 0) ? $urandom_range(len, 1) : 0, t);
        end
        for (int i = 0; i < 512; i++) gl[i] = 1'b0;

        begin
            int d0;
            d0 = done_cnt;
            base_addr = 5'd0; length = 6'd10; fill_value = 8'h42;
            start = 1'b1;
            @(posedge clock); #1;
            start = 1'b0;
            repeat (5) @(posedge clock);
            #2;
            reset_n = 1'b0;
            #1;
            check("arst_req", int'(bus_req), 0);
            check("arst_busy", int'(busy), 0);
            check("arst_drive", int'(bus_drive_en), 0);
            repeat (2) @(posedge clock);
            #3;
            reset_n = 1'b1;
            repeat (5) @(posedge clock);
            #1;
            check("arst_no_done", done_cnt - d0, 0);
            check("arst_idle", int'(busy), 0);
        end
        run(6, 2, 8'h24, 0, t);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
